hex_onehot_decoder: RTL and testbench
=====================================

// Module: hex_onehot_decoder
// PURPOSE
//  Streaming 4-to-16 decoder; the counterpart of the 16-to-4 hexadecimal encoder.
//  Accepts 4-bit hex codes over a valid/ready handshake and buffers them in a small FIFO.
//  Presents each code as a 16-bit one-hot word over a second valid/ready handshake.
//  Sits between a code source (e.g. the encoder or a keypad scanner) and one-hot consumers (LED bank, select lines).
// PARAMETERS
//  DEPTH       2  FIFO entries; power of two, >= 2
//  ACTIVE_LOW  0  1: out_onehot is inverted (one-cold); the idle value becomes 16'hFFFF
//  CNT_W       8  width of the decoded-word counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  en          in   1      1 = accept new codes; 0 = in_ready forced low; the FIFO still drains
//  flush       in   1      synchronous clear of the FIFO contents; the counter is not cleared
//  in_valid    in   1      in_code is valid
//  in_ready    out  1      block can accept a code this cycle
//  in_code     in   4      hex code 0..15
//  out_valid   out  1      out_onehot holds a valid word
//  out_ready   in   1      consumer takes the word this cycle
//  out_onehot  out  16     decoded word: bit[in_code] set (inverted when ACTIVE_LOW=1)
//  out_code    out  4      raw code of the head entry, for checking
//  dec_count   out  CNT_W  number of words popped; saturates at all-ones
// BEHAVIOUR
//  Reset values (rst_n low, asynchronous):
//   - FIFO empty; wr_ptr = rd_ptr = 0
//   - in_ready = 0; out_valid = 0; out_code = 0; dec_count = 0
//   - out_onehot = idle value (16'h0000, or 16'hFFFF when ACTIVE_LOW=1)
//   - Release takes effect on the first clk edge after rst_n rises.
//   - in_ready is registered; it goes to 1 in the cycle after release.
//  Push: in_valid & in_ready at edge N.
//   - The code is decoded at write time, and the 16-bit word plus the code are stored.
//  Pop: out_valid & out_ready at edge N.
//   - The head advances; dec_count increments unless it is already all-ones.
//  in_ready = en & !full & !flush, from registered state.
//   - When full, no push is allowed even if a pop occurs in the same cycle (no pass-through).
//  out_valid = !empty.
//   - out_onehot and out_code are driven from the registered head entry.
//   - While empty: out_onehot = idle value and out_code = 0.
//  Latency: a code pushed at edge N is visible on out_valid/out_onehot after edge N, provided the FIFO was empty.
//  Push and pop in the same edge when not full and not empty: the occupancy count is unchanged and both succeed.
//  Pointers: log2(DEPTH) bits plus one wrap bit. Full = addresses equal and wrap bits differ. Empty = pointers equal.
//  Flush has priority over push and pop in the same cycle:
//   - Pointers are cleared and out_valid = 0 next cycle.
//   - A pop attempted in the flush cycle does not count.
//  Every 4-bit value 0..15 is legal; there is no error path.
//  Reset mid-transfer discards all entries immediately; no partial state is retained.
//  The outputs hold stable while out_valid=1 and out_ready=0.
// TESTING
//  1. Reset, push code 4'hA -> next cycle out_valid=1, out_onehot=16'h0400, out_code=4'hA.
//  2. Push 0..15 with out_ready=1 -> out_onehot=1<<k in order; dec_count=16; no out_onehot bit is ever set twice.
//  3. DEPTH=2, out_ready=0, push 3 then 7 -> in_ready=0 after the 2nd push; 3rd code (9) is held by the source.
//     Then release out_ready -> outputs 16'h0008, 16'h0080, 16'h0200.
//  4. Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> pop only; the push happens the next cycle.
//  5. flush=1 with 2 entries and out_ready=1 -> out_valid=0 next cycle; dec_count unchanged.
//  6. ACTIVE_LOW=1, CNT_W=2: push 5 words -> first word is 16'hFFDF for code 5; dec_count saturates at 3.
//     Assert rst_n low mid-stream -> out_valid=0 and dec_count=0 immediately.

Source files
------------

// File: rtl/hex_onehot_decoder.sv
// Streaming 4-to-16 decoder: hex codes enter over a valid/ready handshake,
// are decoded to a 16-bit one-hot word at write time, buffered in a small
// FIFO, and presented over a second valid/ready handshake.
module hex_onehot_decoder #(
    parameter int unsigned DEPTH      = 2,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_onehot,
    output logic [3:0]       out_code,
    output logic [CNT_W-1:0] dec_count
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW        = AW + 1;
    localparam logic [15:0] IDLE_WORD = ACTIVE_LOW ? 16'hFFFF : 16'h0000;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Storage: decoded word and raw code per entry
    logic [15:0]      word_q [DEPTH];
    logic [15:0]      word_d [DEPTH];
    logic [3:0]       code_q [DEPTH];
    logic [3:0]       code_d [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_onehot_q, out_onehot_d;
    logic [3:0]       out_code_q, out_code_d;
    logic [CNT_W-1:0] dec_count_q, dec_count_d;

    logic             push, pop;
    logic             full_d, empty_d;
    logic [15:0]      decoded;
    logic [AW-1:0]    head_idx;

    // Next-state: handshakes, storage write, pointer update and registered outputs
    always_comb begin
        word_d       = word_q;
        code_d       = code_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        dec_count_d  = dec_count_q;
        push         = 1'b0;
        pop          = 1'b0;
        decoded      = 16'(1) << in_code;
        if (ACTIVE_LOW) begin
            decoded = ~decoded;
        end

        // Flush overrides both handshakes; a pop in the flush cycle is not counted
        push = in_valid  & in_ready_q  & ~flush;
        pop  = out_valid_q & out_ready & ~flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                word_d[wr_ptr_q[AW-1:0]] = decoded;
                code_d[wr_ptr_q[AW-1:0]] = in_code;
                wr_ptr_d                 = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (dec_count_q != CNT_MAX) begin
                    dec_count_d = dec_count_q + CNT_W'(1);
                end
            end
        end

        full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                   (wr_ptr_d[PW-1]   != rd_ptr_d[PW-1]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        head_idx = rd_ptr_d[AW-1:0];

        // Head entry is read from next-state storage so a push into an empty FIFO shows next cycle
        in_ready_d   = en & ~full_d & ~flush;
        out_valid_d  = ~empty_d;
        out_onehot_d = empty_d ? IDLE_WORD : word_d[head_idx];
        out_code_d   = empty_d ? 4'h0      : code_d[head_idx];
    end

    // State registers; reset discards every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                word_q[i] <= IDLE_WORD;
                code_q[i] <= 4'h0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_onehot_q <= IDLE_WORD;
            out_code_q   <= 4'h0;
            dec_count_q  <= '0;
        end else begin
            word_q       <= word_d;
            code_q       <= code_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_code_q   <= out_code_d;
            dec_count_q  <= dec_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_code   = out_code_q;
    assign dec_count  = dec_count_q;

endmodule

// File: tb/tb_hex_onehot_decoder.sv
// Directed bench for hex_onehot_decoder: a default instance (DEPTH=2,
// active-high, 8-bit counter) and a one-cold instance with a 2-bit counter.
module tb_hex_onehot_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_rst_n, a_en, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]  a_in_code, a_out_code;
    logic [15:0] a_out_onehot;
    logic [7:0]  a_dec_count;

    // Instance B: one-cold, saturating 2-bit counter
    logic        b_rst_n, b_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]  b_in_code, b_out_code;
    logic [15:0] b_out_onehot;
    logic [1:0]  b_dec_count;

    hex_onehot_decoder #(.DEPTH(2), .ACTIVE_LOW(1'b0), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_onehot(a_out_onehot), .out_code(a_out_code), .dec_count(a_dec_count)
    );

    hex_onehot_decoder #(.DEPTH(2), .ACTIVE_LOW(1'b1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_onehot(b_out_onehot), .out_code(b_out_code), .dec_count(b_dec_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus and the outputs expected after the edge
    typedef struct {
        logic        en;
        logic        flush;
        logic        iv;
        logic [3:0]  code;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_oh;
        logic [3:0]  e_code;
        logic [7:0]  e_cnt;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    logic [3:0]  b_codes [5];
    logic [15:0] b_exp   [5];

    initial begin
        //            en    flush iv    code   ordy   ir    ov    onehot     code   cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 8'd0}; // ready after release
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 16'h0400, 4'hA, 8'd0}; // push A
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 8'd1}; // pop A
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 16'h0008, 4'h3, 8'd1}; // push 3
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 16'h0008, 4'h3, 8'd1}; // push 7 -> full
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 16'h0008, 4'h3, 8'd1}; // 9 held, outputs stable
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 16'h0080, 4'h7, 8'd2}; // full: pop only
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 16'h0080, 4'h7, 8'd2}; // 9 pushed now
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 16'h0200, 4'h9, 8'd3}; // pop 7
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 8'd4}; // pop 9
        vecs[10] = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 16'h0002, 4'h1, 8'd4}; // push 1
        vecs[11] = '{1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 16'h0002, 4'h1, 8'd4}; // push 2 -> full
        vecs[12] = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'd4}; // flush wins
        vecs[13] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 8'd4}; // ready again
        vecs[14] = '{1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1, 16'h0040, 4'h6, 8'd4}; // push 6
        vecs[15] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 16'h8000, 4'hF, 8'd5}; // push F + pop 6
        vecs[16] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h0, 8'd6}; // pop F
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 8'd6}; // en low
        vecs[18] = '{1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 8'd6}; // no accept
        vecs[19] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 8'd6}; // en back
        vecs[20] = '{1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1, 16'h1000, 4'hC, 8'd6}; // push C
        vecs[21] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1000, 4'hC, 8'd6}; // en low, entry held
        vecs[22] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 8'd7}; // drains with en low
        vecs[23] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 8'd7}; // idle
        b_codes = '{4'h5, 4'h1, 4'h2, 4'h3, 4'h4};
        b_exp   = '{16'hFFDF, 16'hFFFD, 16'hFFFB, 16'hFFF7, 16'hFFEF};

        a_rst_n = 1'b0; a_en = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_code = 4'h0; a_out_ready = 1'b0;
        b_rst_n = 1'b0; b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_code = 4'h0; b_out_ready = 1'b0;

        // Reset values, sampled after an edge inside reset
        #12;
        check("rst_a_in_ready",  32'(a_in_ready),   32'h0);
        check("rst_a_out_valid", 32'(a_out_valid),  32'h0);
        check("rst_a_onehot",    32'(a_out_onehot), 32'h0000);
        check("rst_a_code",      32'(a_out_code),   32'h0);
        check("rst_a_count",     32'(a_dec_count),  32'h0);
        check("rst_b_onehot",    32'(b_out_onehot), 32'hFFFF);
        check("rst_b_out_valid", 32'(b_out_valid),  32'h0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Table-driven vectors on instance A
        for (int i = 0; i < NV; i++) begin
            a_en = vecs[i].en; a_flush = vecs[i].flush; a_in_valid = vecs[i].iv;
            a_in_code = vecs[i].code; a_out_ready = vecs[i].ordy;
            @(posedge clk); #1;
            check($sformatf("v%0d_in_ready", i),  32'(a_in_ready),   32'(vecs[i].e_ir));
            check($sformatf("v%0d_out_valid", i), 32'(a_out_valid),  32'(vecs[i].e_ov));
            check($sformatf("v%0d_onehot", i),    32'(a_out_onehot), 32'(vecs[i].e_oh));
            check($sformatf("v%0d_code", i),      32'(a_out_code),   32'(vecs[i].e_code));
            check($sformatf("v%0d_count", i),     32'(a_dec_count),  32'(vecs[i].e_cnt));
        end

        // Stream codes 0..15 with the consumer always ready
        begin
            int pushed = 0;
            int popped = 0;
            int cyc = 0;
            logic [15:0] seen = 16'h0000;
            a_en = 1'b1; a_flush = 1'b0; a_out_ready = 1'b1;
            while (popped < 16 && cyc < 100) begin
                a_in_valid = (pushed < 16);
                a_in_code  = 4'(pushed);
                if (a_out_valid) begin
                    check($sformatf("stream_word%0d", popped), 32'(a_out_onehot), 32'(16'(1) << popped));
                    check($sformatf("stream_dup%0d", popped),  32'(seen & a_out_onehot), 32'h0);
                    seen = seen | a_out_onehot;
                    popped++;
                end
                if (a_in_valid && a_in_ready) pushed++;
                @(posedge clk); #1;
                cyc++;
            end
            a_in_valid = 1'b0;
            check("stream_all_popped", 32'(popped), 32'd16);
            check("stream_mask",       32'(seen),   32'hFFFF);
            check("stream_count",      32'(a_dec_count), 32'd23);
            check("stream_empty",      32'(a_out_valid), 32'h0);
        end

        // Instance B: one-cold words and counter saturation
        begin
            int pushed = 0;
            int popped = 0;
            int cyc = 0;
            b_out_ready = 1'b1;
            while (popped < 5 && cyc < 50) begin
                b_in_valid = (pushed < 5);
                b_in_code  = (pushed < 5) ? b_codes[pushed] : 4'h0;
                if (b_out_valid) begin
                    check($sformatf("b_word%0d", popped), 32'(b_out_onehot), 32'(b_exp[popped]));
                    check($sformatf("b_code%0d", popped), 32'(b_out_code),   32'(b_codes[popped]));
                    popped++;
                end
                if (b_in_valid && b_in_ready) pushed++;
                @(posedge clk); #1;
                cyc++;
            end
            b_in_valid = 1'b0;
            check("b_all_popped", 32'(popped), 32'd5);
            check("b_saturated",  32'(b_dec_count), 32'd3);
            check("b_idle_word",  32'(b_out_onehot), 32'hFFFF);
        end

        // Reset mid-stream on B clears everything without waiting for a clock
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_code = 4'h8;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("b_held_word",  32'(b_out_onehot), 32'hFEFF);
        check("b_held_valid", 32'(b_out_valid),  32'h1);
        #2;
        b_rst_n = 1'b0;
        #1;
        check("b_rst_valid",  32'(b_out_valid),  32'h0);
        check("b_rst_count",  32'(b_dec_count),  32'h0);
        check("b_rst_onehot", 32'(b_out_onehot), 32'hFFFF);
        check("b_rst_ready",  32'(b_in_ready),   32'h0);
        #5;
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        check("b_rel_ready",  32'(b_in_ready),   32'h1);
        check("b_rel_valid",  32'(b_out_valid),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
